module_disp_sched: RTL

Display scheduler for the 4-digit multiplexed seven-segment path. It time-shares the display between two BCD sources. Source A is the live keypad/entry digits, level-valid. Source B is the converter result, delivered by valid/ready handshake and held on screen for a fixed time. The block generates the digit scan rate and frame-aligned buffer updates, and drives the BCD digit, one-hot transistor enable and blank flag into the segment decoder stage.

---
 rtl/module_disp_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/module_disp_sched.sv
// module_disp_sched
// Display scheduler for the 4-digit multiplexed seven-segment path.
// Time-shares the display between live entry digits (source A, level-valid)
// and converter results (source B, valid/ready, held for HOLD_FRAMES frames).
// Optional build macro: DISP_LZB_EN enables leading-zero blanking.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | nothing to show; all digit enables off, blanked
// SHOW_A | scanning buf_a (live entry digits, or last ones seen)
// SHOW_B | scanning buf_b for hold frames, then back to A or IDLE
//
// Every state change happens on a frame boundary, so a frame never mixes
// sources; outputs are registered on the tick edge from next-cycle values.
module module_disp_sched #(
    parameter int SCAN_DIV    = 27000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [15:0] a_digits,
    input  logic        b_valid,
    input  logic [15:0] b_digits,
    output logic        b_ready,
    output logic [3:0]  digit,
    output logic [3:0]  transis,
    output logic        blank,
    output logic        src
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;
    logic [HW-1:0]   hold;
    logic [HW-1:0]   hold_nxt;
    logic [15:0]     buf_a;
    logic [15:0]     buf_b;
    logic [15:0]     pend_b;
    logic            pend_full;
    logic            a_seen;
    logic            tick;
    logic            frame_end;
    logic            xfer;
    logic            commit;
    logic [15:0]     buf_a_nxt;
    logic [15:0]     buf_b_nxt;
    logic [15:0]     shown;
    logic [3:0]      nib;
    logic            lead_zero;

    assign tick      = (presc == PRESC_LAST);
    assign frame_end = tick && (idx == 2'd3);
    assign xfer      = b_valid && b_ready;
    assign commit    = frame_end && pend_full;
    assign idx_nxt   = tick ? idx + 2'd1 : idx;

    // Prescaler and scan index: one slot per SCAN_DIV cycles, four slots per frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            idx   <= 2'd0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) idx <= idx + 2'd1;
        end
    end

    // Source buffers and the single-entry B pending slot with its ready flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_a     <= '0;
            buf_b     <= '0;
            pend_b    <= '0;
            pend_full <= 1'b0;
            a_seen    <= 1'b0;
            b_ready   <= 1'b0;
        end else begin
            if (a_valid) begin
                buf_a  <= a_digits;
                a_seen <= 1'b1;
            end
            if (xfer) begin
                pend_b    <= b_digits;
                pend_full <= 1'b1;
            end else if (commit) begin
                buf_b     <= pend_b;
                pend_full <= 1'b0;
            end
            b_ready <= !(xfer || (pend_full && !commit));
        end
    end

    // State and hold-frame register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
        end
    end

    // Next-state logic; a B commit always beats any A-driven transition.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt = SHOW_B;
                    hold_nxt  = HOLD_INIT;
                end else if (frame_end && a_valid) begin
                    state_nxt = SHOW_A;
                end
            end
            SHOW_A: begin
                if (commit) begin
                    state_nxt = SHOW_B;
                    hold_nxt  = HOLD_INIT;
                end
            end
            SHOW_B: begin
                if (commit) begin
                    hold_nxt = HOLD_INIT;
                end else if (frame_end) begin
                    if (hold <= HOLD_ONE) begin
                        hold_nxt  = '0;
                        state_nxt = (a_seen || a_valid) ? SHOW_A : IDLE;
                    end else begin
                        hold_nxt = hold - HW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // Digit and leading-zero flag for the slot that becomes visible next.
    always_comb begin
        buf_a_nxt = a_valid ? a_digits : buf_a;
        buf_b_nxt = commit ? pend_b : buf_b;
        shown     = (state_nxt == SHOW_B) ? buf_b_nxt : buf_a_nxt;
        nib       = shown[{idx_nxt, 2'b00} +: 4];
        lead_zero = 1'b0;
        case (idx_nxt)
            2'd3:    lead_zero = (shown[15:12] == 4'd0);
            2'd2:    lead_zero = (shown[15:8] == 8'd0);
            2'd1:    lead_zero = (shown[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    // Registered display outputs, refreshed only on slot boundaries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            digit   <= 4'd0;
            transis <= 4'b0000;
            blank   <= 1'b1;
            src     <= 1'b0;
        end else if (tick) begin
            if (state_nxt == IDLE) begin
                digit   <= 4'd0;
                transis <= 4'b0000;
                blank   <= 1'b1;
                src     <= 1'b0;
            end else begin
                digit   <= nib;
                transis <= 4'b0001 << idx_nxt;
`ifdef DISP_LZB_EN
                blank   <= lead_zero;
`else
                blank   <= 1'b0;
`endif
                src     <= (state_nxt == SHOW_B);
            end
        end
    end

endmodule
